// File: rtl/hdmi_fb_reader_if.sv
// Framebuffer read ports, buffer handover and video outputs of the scan-out block.
// master = scan-out block, slave = BRAM pair / display sink.
interface hdmi_fb_reader_if #(
    parameter int ADDR_WIDTH = 19
);
    logic                  bufSel;
    logic                  RD0;
    logic                  RD1;
    logic                  EN0;
    logic [ADDR_WIDTH-1:0] addrB0;
    logic                  EN1;
    logic [ADDR_WIDTH-1:0] addrB1;
    logic                  activeBuf;
    logic                  frameDone;
    logic                  VDEn;
    logic                  hSync;
    logic                  vSync;
    logic [23:0]           pixel;

    modport master (
        input  bufSel, RD0, RD1,
        output EN0, addrB0, EN1, addrB1, activeBuf, frameDone,
        output VDEn, hSync, vSync, pixel
    );

    modport slave (
        output bufSel, RD0, RD1,
        input  EN0, addrB0, EN1, addrB1, activeBuf, frameDone,
        input  VDEn, hSync, vSync, pixel
    );
endinterface

// File: rtl/hdmi_fb_reader.sv
// Raster scan-out of a 1-bit ping-pong framebuffer: video timing, BRAM reads, colour expansion.
// Counter-to-output latency RD_LAT+1 clocks; free-running, no backpressure (the display sets the pace).
module hdmi_fb_reader #(
    parameter int          ADDR_WIDTH = 19,
    parameter int          WIDTH      = 1024,
    parameter int          HEIGHT     = 512,
    parameter int          HFP        = 24,
    parameter int          HS         = 136,
    parameter int          HBP        = 160,
    parameter int          VFP        = 3,
    parameter int          VS         = 6,
    parameter int          VBP        = 29,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int          RD_LAT     = 1,
    parameter logic [23:0] FG_COLOR   = 24'hFFFF00,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic             clk,
    input  logic             rst,
    hdmi_fb_reader_if.master bus
);
    localparam int H_TOTAL = WIDTH + HFP + HS + HBP;
    localparam int V_TOTAL = HEIGHT + VFP + VS + VBP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic sel;
    } tap_t;

    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  active_buf;
    logic                  frame_done;
    logic                  active;
    logic                  hs_raw;
    logic                  vs_raw;
    logic                  line_end;
    logic                  frame_end;
    logic                  rd_bit;
    tap_t                  pipe [RD_LAT];
    tap_t                  tail;

    // Compare in 32 bits so sync window edges equal to 2**HW do not wrap.
    always_comb begin
        line_end  = (32'(h_cnt) == H_TOTAL - 1);
        frame_end = line_end && (32'(v_cnt) == V_TOTAL - 1);
        active    = (32'(h_cnt) < WIDTH) && (32'(v_cnt) < HEIGHT);
        hs_raw    = (32'(h_cnt) >= WIDTH + HFP) && (32'(h_cnt) < WIDTH + HFP + HS);
        vs_raw    = (32'(v_cnt) >= HEIGHT + VFP) && (32'(v_cnt) < HEIGHT + VFP + VS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr    <= '0;
            active_buf <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (frame_end) begin
                rd_addr    <= '0;
                active_buf <= bus.bufSel;
            end else if (active) begin
                rd_addr <= rd_addr + 1'b1;
            end
            frame_done <= (32'(h_cnt) == WIDTH - 1) && (32'(v_cnt) == HEIGHT - 1);
        end
    end

    // Reads stay quiet while held in reset even though the counters sit on an active pixel.
    assign bus.EN0       = rst & active & ~active_buf;
    assign bus.EN1       = rst & active & active_buf;
    assign bus.addrB0    = rd_addr;
    assign bus.addrB1    = rd_addr;
    assign bus.activeBuf = active_buf;
    assign bus.frameDone = frame_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {active, hs_raw, vs_raw, active_buf};
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail   = pipe[RD_LAT-1];
    assign rd_bit = tail.sel ? bus.RD1 : bus.RD0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.VDEn  <= 1'b0;
            bus.pixel <= '0;
            bus.hSync <= ~SYNC_POL;
            bus.vSync <= ~SYNC_POL;
        end else begin
            bus.VDEn  <= tail.act;
            bus.pixel <= tail.act ? (rd_bit ? FG_COLOR : BG_COLOR) : 24'h0;
            bus.hSync <= tail.hs ? SYNC_POL : ~SYNC_POL;
            bus.vSync <= tail.vs ? SYNC_POL : ~SYNC_POL;
        end
    end
endmodule
